// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply, 32-step restoring divide.
// Optional accumulate ops (MADD/MADDU) are built only when MDU_MADD_EN is defined.
module mdu_iter #(
  parameter int MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        sgn_q;      // signed multiply
  logic [31:0] a_q;        // multiplicand
  logic [31:0] b_q;        // multiplier, or divisor magnitude
  logic [31:0] rem;        // partial remainder
  logic [31:0] quo;        // dividend bits shifting out, quotient bits shifting in
  logic        neg_quo_q;
  logic        neg_rem_q;
`ifdef MDU_MADD_EN
  logic        madd_q;
`endif

  assign busy = (state != S_IDLE);

  // Multiply datapath: 64-bit product of the sign- or zero-extended latched operands.
  logic [63:0] a_ext, b_ext, product, mul_res;
  always_comb begin
    a_ext   = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext   = {{32{sgn_q & b_q[31]}}, b_q};
    product = a_ext * b_ext;
`ifdef MDU_MADD_EN
    // HI/LO cannot change while busy, so the live value equals the one held at issue.
    mul_res = madd_q ? (product + {hi, lo}) : product;
`else
    mul_res = product;
`endif
  end

  // One restoring-divide step on a 33-bit shifted partial remainder.
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt, quo_fix, rem_fix;
  always_comb begin
    shifted = {rem, quo[31]};
    ge      = (shifted >= {1'b0, b_q});
    rem_nxt = ge ? 32'(shifted - {1'b0, b_q}) : shifted[31:0];
    quo_nxt = {quo[30:0], ge};
    quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  logic        div_signed;
  logic [31:0] a_mag, b_mag;
  always_comb begin
    div_signed = (op == OP_DIV);
    a_mag      = (div_signed && a[31]) ? -a : a;
    b_mag      = (div_signed && b[31]) ? -b : b;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: operand and datapath flops are reset too; they are few and this keeps reset state deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem       <= '0;
      quo       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef MDU_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state <= S_MUL;
                cnt   <= 6'(MULT_LAT);
                sgn_q <= ~op[0];
                a_q   <= a;
                b_q   <= b;
`ifdef MDU_MADD_EN
                madd_q <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                if (b != '0) begin
                  state     <= S_DIV;
                  cnt       <= 6'd32;
                  quo       <= a_mag;
                  b_q       <= b_mag;
                  rem       <= '0;
                  neg_quo_q <= div_signed & (a[31] ^ b[31]);
                  neg_rem_q <= div_signed & a[31];
                end
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
`ifdef MDU_MADD_EN
              OP_MADD, OP_MADDU: begin
                state  <= S_MUL;
                cnt    <= 6'(MULT_LAT);
                sgn_q  <= ~op[0];
                a_q    <= a;
                b_q    <= b;
                madd_q <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == 6'd1) begin
            state    <= S_IDLE;
            cnt      <= '0;
            {hi, lo} <= mul_res;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == 6'd1) begin
            state <= S_IDLE;
            cnt   <= '0;
            lo    <= quo_fix;
            hi    <= rem_fix;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multiply/divide unit (MDU) in the EX stage. Sits directly downstream of the ID-stage operand/immediate path and beside the ALU.
- Consumes the forwarded rs/rt operand values and owns the architectural HI/LO registers.
- Executes MULT/MULTU at a fixed latency and DIV/DIVU as a 32-iteration restoring divider.
- Raises busy so hazard logic stalls any following MDU instruction (mf*, mt*, mult/div) until the result is written.

Parameters:
- MULT_LAT, 5: busy cycles for MULT/MULTU/MADD/MADDU. Legal range 1..15.

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  Issue strobe; sampled only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6=MADD, 7=MADDU.
- a  in  32  rs operand (dividend / multiplicand / MT source).
- b  in  32  rt operand (divisor / multiplier).
- busy  out  1  High while a multiply or divide is in flight.
- hi  out  32  HI register, driven directly from a flop.
- lo  out  32  LO register, driven directly from a flop.

Behaviour:
- Reset (reset_n=0, asynchronous): hi=0, lo=0, busy=0, state=IDLE, iteration counter=0.
- Reset mid-operation aborts the operation. HI/LO are not written with the partial result.
- States are IDLE, MUL and DIV. busy=1 exactly when state≠IDLE.
- start while busy=1 is ignored: no queueing, no effect.
- a and b are latched on the start edge. Later changes to a or b have no effect.
- IDLE with start and op=4/5: hi (op=4) or lo (op=5) takes a on that edge. busy stays 0.
- IDLE with start and op=0/1: go to MUL and load counter=MULT_LAT.
  - busy is high for exactly MULT_LAT cycles.
  - On the edge that ends the last busy cycle, {hi,lo}=64-bit product (signed for op=0, unsigned for op=1) and state returns to IDLE.
  - The new HI/LO values are therefore visible in the first cycle with busy=0.
- IDLE with start and op=2/3, b≠0: go to DIV and load counter=32.
  - Signed ops (op=2) convert a and b to magnitudes first.
  - One restoring step per cycle (33-bit partial remainder).
  - busy is high for exactly 32 cycles.
  - On the final edge: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend. Then return to IDLE.
- Divide by zero (op=2/3, b=0): ignored. busy stays 0 and hi/lo are unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- The result write and the busy falling edge occur on the same clock edge. There is no extra turnaround cycle.
- A start issued in the same cycle busy drops is accepted, because state is already IDLE in that cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined:
  - op=6 computes {hi,lo} += signed a*b; op=7 computes {hi,lo} += unsigned a*b.
  - The accumulation wraps modulo 2^64.
  - Same MUL state and MULT_LAT latency as MULT.
  - The {hi,lo} value captured on the start edge is used as the addend.
- When not defined: op=6/7 are no-ops. busy stays 0, hi/lo are unchanged, and no accumulate hardware is synthesized.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release -> hi=0, lo=0, busy=0; no activity after release.
- MULT/MULTU: MULT a=0xFFFFFFFE b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002 lo=0xFFFFFFFA.
- DIV/DIVU: DIV a=0xFFFFFFF9 b=2 -> busy for 32 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1.
- Edge divides: DIV with b=0 -> busy never rises and hi/lo are unchanged. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- Issue rules: MTHI a=0x1234 in IDLE -> hi=0x1234 on the next edge. start with op=3 during an in-flight MULT -> ignored, and the MULT result is unchanged. Back-to-back MULT issued in the busy-fall cycle -> accepted.
- Async reset: pull reset_n low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately without waiting for a clock edge. With MDU_MADD_EN: hi:lo=0:5, then MADD a=2 b=3 -> lo=11 hi=0.
